// File: rtl/complex_mixer.sv
// Complex mixer: multiplies a real or complex input sample by an NCO sample (optionally
// conjugated), rounds half-up to OUT_WIDTH, saturates and counts saturated outputs.
// Pipeline: input register -> product register -> sum register -> output register,
// so opValid rises on the third edge after the edge that captured ipValid.
module complex_mixer #(
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned NCO_WIDTH   = 18,
  parameter int unsigned OUT_WIDTH   = 18,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   ipClk,
  input  logic                   ipReset,
  input  logic                   ipValid,
  input  logic [IN_WIDTH-1:0]    ipInputI,
  input  logic [IN_WIDTH-1:0]    ipInputQ,
  input  logic [NCO_WIDTH-1:0]   ipNCO_I,
  input  logic [NCO_WIDTH-1:0]   ipNCO_Q,
  input  logic                   ipComplex,
  input  logic                   ipConjugate,
  input  logic                   ipClearCount,
  output logic                   opValid,
  output logic [OUT_WIDTH-1:0]   opOutputI,
  output logic [OUT_WIDTH-1:0]   opOutputQ,
  output logic                   opOverflow,
  output logic [COUNT_WIDTH-1:0] opOverflowCount
);

  // Product width, sum width (one guard bit) and rounding width (one more for the +half).
  localparam int unsigned PW       = IN_WIDTH + NCO_WIDTH;
  localparam int unsigned SW       = PW + 1;
  localparam int unsigned RW       = SW + 1;
  // Products carry 2 integer bits, the output 1, so drop this many fraction bits.
  localparam int unsigned SHIFT    = IN_WIDTH + NCO_WIDTH - 1 - OUT_WIDTH;
  localparam int unsigned SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [RW-1:0]        RND     = (SHIFT > 0) ? (RW'(1) << SHIFT_M1) : '0;
  localparam logic signed [RW-1:0] SAT_MAX = (RW'(1) << (OUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  // Returns {saturated, value}: round half up then clamp to the output range.
  function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [SW-1:0] y);
    logic signed [RW-1:0] v;
    v = {y[SW-1], y} + RND;
    v = v >>> SHIFT;
    if (v > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    end else if (v < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    end
    return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  // Stage 1: captured sample; Q is forced to zero in real mode so one datapath serves both.
  logic                 r_s1_valid;
  logic                 r_s1_conj;
  logic [IN_WIDTH-1:0]  r_s1_ai;
  logic [IN_WIDTH-1:0]  r_s1_aq;
  logic [NCO_WIDTH-1:0] r_s1_bi;
  logic [NCO_WIDTH-1:0] r_s1_bq;

  // Stage 2: the four partial products.
  logic                 r_s2_valid;
  logic                 r_s2_conj;
  logic signed [PW-1:0] r_s2_p_ii;
  logic signed [PW-1:0] r_s2_p_qq;
  logic signed [PW-1:0] r_s2_p_iq;
  logic signed [PW-1:0] r_s2_p_qi;

  // Stage 3: exact complex sums.
  logic                 r_s3_valid;
  logic signed [SW-1:0] r_s3_yi;
  logic signed [SW-1:0] r_s3_yq;

  // Output registers.
  logic                   r_out_valid;
  logic [OUT_WIDTH-1:0]   r_out_i;
  logic [OUT_WIDTH-1:0]   r_out_q;
  logic                   r_out_ovf;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_count_d;

  // Sign-extended multiplier operands and products.
  logic signed [PW-1:0] w_ai_x;
  logic signed [PW-1:0] w_aq_x;
  logic signed [PW-1:0] w_bi_x;
  logic signed [PW-1:0] w_bq_x;
  logic signed [PW-1:0] w_p_ii;
  logic signed [PW-1:0] w_p_qq;
  logic signed [PW-1:0] w_p_iq;
  logic signed [PW-1:0] w_p_qi;

  logic signed [SW-1:0] w_x_ii;
  logic signed [SW-1:0] w_x_qq;
  logic signed [SW-1:0] w_x_iq;
  logic signed [SW-1:0] w_x_qi;
  logic signed [SW-1:0] w_yi;
  logic signed [SW-1:0] w_yq;

  logic [OUT_WIDTH:0] w_ri;
  logic [OUT_WIDTH:0] w_rq;
  logic               w_ovf;

  // Pipeline valid bits; reset discards anything in flight.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= ipValid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Stage 1 data capture; mode bits travel with the sample.
  always_ff @(posedge ipClk) begin
    if (ipValid) begin
      r_s1_ai   <= ipInputI;
      r_s1_aq   <= ipComplex ? ipInputQ : '0;
      r_s1_bi   <= ipNCO_I;
      r_s1_bq   <= ipNCO_Q;
      r_s1_conj <= ipConjugate;
    end
  end

  // Sign-extend to full product width so every multiply is PW x PW -> PW and exact.
  always_comb begin
    w_ai_x = {{NCO_WIDTH{r_s1_ai[IN_WIDTH-1]}}, r_s1_ai};
    w_aq_x = {{NCO_WIDTH{r_s1_aq[IN_WIDTH-1]}}, r_s1_aq};
    w_bi_x = {{IN_WIDTH{r_s1_bi[NCO_WIDTH-1]}}, r_s1_bi};
    w_bq_x = {{IN_WIDTH{r_s1_bq[NCO_WIDTH-1]}}, r_s1_bq};
    w_p_ii = w_ai_x * w_bi_x;
    w_p_qq = w_aq_x * w_bq_x;
    w_p_iq = w_ai_x * w_bq_x;
    w_p_qi = w_aq_x * w_bi_x;
  end

  // Stage 2 product registers.
  always_ff @(posedge ipClk) begin
    if (r_s1_valid) begin
      r_s2_conj <= r_s1_conj;
      r_s2_p_ii <= w_p_ii;
      r_s2_p_qq <= w_p_qq;
      r_s2_p_iq <= w_p_iq;
      r_s2_p_qi <= w_p_qi;
    end
  end

  // a*b = (ii - qq) + j(iq + qi); a*conj(b) = (ii + qq) + j(qi - iq).
  always_comb begin
    w_x_ii = {r_s2_p_ii[PW-1], r_s2_p_ii};
    w_x_qq = {r_s2_p_qq[PW-1], r_s2_p_qq};
    w_x_iq = {r_s2_p_iq[PW-1], r_s2_p_iq};
    w_x_qi = {r_s2_p_qi[PW-1], r_s2_p_qi};
    if (r_s2_conj) begin
      w_yi = w_x_ii + w_x_qq;
      w_yq = w_x_qi - w_x_iq;
    end else begin
      w_yi = w_x_ii - w_x_qq;
      w_yq = w_x_iq + w_x_qi;
    end
  end

  // Stage 3 sum registers.
  always_ff @(posedge ipClk) begin
    if (r_s2_valid) begin
      r_s3_yi <= w_yi;
      r_s3_yq <= w_yq;
    end
  end

  // Round, saturate and work out the next overflow count.
  always_comb begin
    w_ri  = round_sat(r_s3_yi);
    w_rq  = round_sat(r_s3_yq);
    w_ovf = r_s3_valid & (w_ri[OUT_WIDTH] | w_rq[OUT_WIDTH]);
    w_count_d = r_count;
    if (ipClearCount) begin
      w_count_d = w_ovf ? COUNT_WIDTH'(1) : '0;
    end else if (w_ovf && !(&r_count)) begin
      w_count_d = r_count + COUNT_WIDTH'(1);
    end
  end

  // Output registers: data holds between valid samples, overflow flag only lives with opValid.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_ovf   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_out_valid <= r_s3_valid;
      r_out_ovf   <= w_ovf;
      r_count     <= w_count_d;
      if (r_s3_valid) begin
        r_out_i <= w_ri[OUT_WIDTH-1:0];
        r_out_q <= w_rq[OUT_WIDTH-1:0];
      end
    end
  end

  assign opValid         = r_out_valid;
  assign opOutputI       = r_out_i;
  assign opOutputQ       = r_out_q;
  assign opOverflow      = r_out_ovf;
  assign opOverflowCount = r_count;

endmodule
